// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants and waveform mode encodings for the DAC waveform generator
package dac_pkg;

    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        MODE_CONST = 2'b00,
        MODE_SAW   = 2'b01,
        MODE_TRI   = 2'b10,
        MODE_SQR   = 2'b11
    } wave_mode_e;

    localparam logic [DATA_W-1:0] FULL_SCALE = {DATA_W{1'b1}};

endpackage

// File: rtl/rate_ticker.sv
// rtl/rate_ticker.sv - sample-rate divider producing a one-cycle tick every rate_div+1 enabled cycles
module rate_ticker #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    // >= rather than == so a rate_div lowered mid-count cannot strand the counter
    assign w_wrap = (r_cnt >= rate_div);
    assign tick   = en && w_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/dac_wave_gen.sv
// rtl/dac_wave_gen.sv - waveform generator (const/saw/triangle/square) feeding a DAC7611P driver via valid/ready
module dac_wave_gen
    import dac_pkg::*;
#(
    parameter int DATA_W = dac_pkg::DATA_W,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] step,
    input  logic [DATA_W-1:0] level,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              dac_ready,
    output logic [DATA_W-1:0] DATA,
    output logic              data_valid,
    output logic [7:0]        overrun
);

    localparam logic [DATA_W-1:0] MAX_CODE = {DATA_W{1'b1}};

    logic              w_tick;
    logic              w_load;
    logic              w_drop;
    logic              w_xfer;
    logic              w_entry;
    logic [DATA_W-1:0] w_prev;
    logic              w_up;
    logic              w_sq_high;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_code;
    logic              w_next_up;
    logic              w_next_sq;

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [7:0]        r_overrun;
    logic [DATA_W-1:0] r_acc;
    logic              r_dir_up;
    logic              r_sq_high;
    logic [1:0]        r_mode;

    rate_ticker #(.DIV_W(DIV_W)) u_ticker (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .rate_div (rate_div),
        .tick     (w_tick)
    );

    assign w_xfer = r_valid && dac_ready;
    assign w_load = w_tick && (!r_valid || dac_ready);
    assign w_drop = w_tick && r_valid && !dac_ready;

    // A mode change restarts the generator before the new code is computed
    assign w_entry   = (mode != r_mode);
    assign w_prev    = w_entry ? '0 : r_acc;
    assign w_up      = w_entry ? 1'b1 : r_dir_up;
    assign w_sq_high = w_entry ? 1'b1 : r_sq_high;
    assign w_sum     = {1'b0, w_prev} + {1'b0, step};
    assign w_diff    = {1'b0, w_prev} - {1'b0, step};

    always_comb begin
        w_code    = w_prev;
        w_next_up = w_up;
        w_next_sq = w_sq_high;
        case (mode)
            MODE_CONST: w_code = level;
            MODE_SAW:   w_code = w_sum[DATA_W-1:0];
            MODE_TRI: begin
                if (w_up) begin
                    if (w_sum[DATA_W] || (w_sum[DATA_W-1:0] == MAX_CODE)) begin
                        w_code = MAX_CODE;
                        if (step != '0) w_next_up = 1'b0;
                    end else begin
                        w_code = w_sum[DATA_W-1:0];
                    end
                end else begin
                    if (w_diff[DATA_W] || (w_diff[DATA_W-1:0] == '0)) begin
                        w_code = '0;
                        if (step != '0) w_next_up = 1'b1;
                    end else begin
                        w_code = w_diff[DATA_W-1:0];
                    end
                end
            end
            default: begin
                w_code    = w_sq_high ? level : '0;
                w_next_sq = !w_sq_high;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= '0;
            r_acc     <= '0;
            r_dir_up  <= 1'b1;
            r_sq_high <= 1'b1;
            r_mode    <= MODE_CONST;
        end else begin
            if (w_load) begin
                r_data    <= w_code;
                r_valid   <= 1'b1;
                r_acc     <= w_code;
                r_dir_up  <= w_next_up;
                r_sq_high <= w_next_sq;
                r_mode    <= mode;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_drop && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end
    end

    assign DATA       = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_dac_wave_gen.sv
// tb/tb_dac_wave_gen.sv - directed self-checking bench for dac_wave_gen
module tb_dac_wave_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic [11:0] step;
    logic [11:0] level;
    logic [15:0] rate_div;
    logic        dac_ready;
    logic [11:0] DATA;
    logic        data_valid;
    logic [7:0]  overrun;

    int n_checks = 0;
    int n_fail   = 0;

    dac_wave_gen #(.DATA_W(12), .DIV_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .step       (step),
        .level      (level),
        .rate_div   (rate_div),
        .dac_ready  (dac_ready),
        .DATA       (DATA),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for data_valid at successive negedges; returns the number of cycles waited, 0 on timeout
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic sample(input string tag, input logic [11:0] exp_data, input int exp_gap);
        int n;
        wait_valid(40, n);
        check({tag, "_gap"}, n, exp_gap);
        check(tag, {20'd0, DATA}, {20'd0, exp_data});
    endtask

    initial begin
        int seen;
        reset     = 1'b0;
        en        = 1'b0;
        mode      = 2'b00;
        step      = 12'd0;
        level     = 12'd0;
        rate_div  = 16'd9;
        dac_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {20'd0, DATA}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_overrun", {24'd0, overrun}, 32'd0);
        reset = 1'b1;

        // Enable briefly, then hold off: divider must restart from 0
        en   = 1'b1;
        mode = 2'b01;
        step = 12'd1024;
        repeat (5) @(negedge clk);
        en   = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (data_valid !== 1'b0) seen++;
        end
        check("en_off_no_valid", seen, 0);
        en = 1'b1;

        sample("saw0", 12'd1024, 10);
        sample("saw1", 12'd2048, 10);
        sample("saw2", 12'd3072, 10);
        sample("saw3", 12'd0, 10);
        sample("saw4", 12'd1024, 10);
        check("saw_overrun", {24'd0, overrun}, 32'd0);

        mode = 2'b10;
        step = 12'd1500;
        sample("tri0", 12'd1500, 10);
        sample("tri1", 12'd3000, 10);
        sample("tri2", 12'd4095, 10);
        sample("tri3", 12'd2595, 10);
        sample("tri4", 12'd1095, 10);
        sample("tri5", 12'd0, 10);
        sample("tri6", 12'd1500, 10);

        dac_ready = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            check("bp_data", {20'd0, DATA}, 32'd1500);
            check("bp_valid", {31'd0, data_valid}, 32'd1);
        end
        check("bp_overrun", {24'd0, overrun}, 32'd3);
        dac_ready = 1'b1;
        sample("bp_resume", 12'd3000, 5);

        mode  = 2'b11;
        level = 12'hCCC;
        sample("sqr0", 12'hCCC, 10);
        sample("sqr1", 12'h000, 10);
        sample("sqr2", 12'hCCC, 10);
        mode = 2'b00;
        sample("const0", 12'hCCC, 10);
        sample("const1", 12'hCCC, 10);

        // rate_div 0: tick every cycle, each tick coincides with a transfer
        en       = 1'b0;
        rate_div = 16'd0;
        mode     = 2'b01;
        step     = 12'd1;
        @(negedge clk);
        en = 1'b1;
        sample("fast0", 12'd1, 1);
        sample("fast1", 12'd2, 1);
        sample("fast2", 12'd3, 1);
        check("fast_overrun", {24'd0, overrun}, 32'd3);

        en        = 1'b0;
        dac_ready = 1'b0;
        @(negedge clk);
        check("hold_valid", {31'd0, data_valid}, 32'd1);
        check("hold_data", {20'd0, DATA}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_data", {20'd0, DATA}, 32'd0);
        check("async_rst_valid", {31'd0, data_valid}, 32'd0);
        check("async_rst_overrun", {24'd0, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        en = 1'b1;
        @(negedge clk);
        check("post_rst_first", {20'd0, DATA}, 32'd1);
        repeat (300) @(negedge clk);
        check("sat_overrun", {24'd0, overrun}, 32'd255);
        check("sat_data", {20'd0, DATA}, 32'd1);
        check("sat_valid", {31'd0, data_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_wave_gen.md
DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

Interface
REQ-001 Parameter DATA_W, default 12, sample code width matching the DAC7611P DATA input.
REQ-002 Parameter DIV_W, default 16, width of the sample-rate divider.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 en  input  1  generator enable; 1 = produce samples.
REQ-006 mode  input  2  waveform select: 00 constant, 01 sawtooth, 10 triangle, 11 square.
REQ-007 step  input  DATA_W  code increment per sample (sawtooth/triangle).
REQ-008 level  input  DATA_W  constant value (mode 00) and high value (mode 11).
REQ-009 rate_div  input  DIV_W  sample period minus one, in clk cycles.
REQ-010 dac_ready  input  1  downstream serializer can accept a sample.
REQ-011 DATA  output  DATA_W  sample code to the DAC7611P driver.
REQ-012 data_valid  output  1  DATA holds an unaccepted sample.
REQ-013 overrun  output  8  saturating count of sample ticks dropped while a sample was pending.

Function
REQ-014 Divider counter counts 0..rate_div; tick SHALL pulse 1 cycle when counter == rate_div and en == 1, then counter returns to 0.
REQ-015 en == 0 SHALL hold the divider at 0 and suppress ticks; a pending sample SHALL still complete its handshake.
REQ-016 On a tick with data_valid == 0, the next code SHALL be computed and DATA and data_valid = 1 SHALL be registered on the following edge (latency 1 cycle after tick).
REQ-017 Handshake: a transfer occurs on an edge where data_valid && dac_ready; data_valid SHALL drop on that edge unless a new sample is loaded on the same edge.
REQ-018 DATA SHALL stay stable while data_valid == 1 and dac_ready == 0.
REQ-019 Tick while data_valid == 1 and no transfer on that edge: sample dropped, generator state not advanced, overrun += 1, saturating at 255.
REQ-020 Tick coincident with a transfer SHALL load the new sample (data_valid stays 1); no overrun.
REQ-021 Mode 00: code = level every sample.
REQ-022 Mode 01: code = (prev + step) mod 2^DATA_W; wrap-around is silent.
REQ-023 Mode 10: direction up: code = min(prev + step, 2^DATA_W - 1), flip to down on reaching max; down: code = max(prev - step, 0), flip to up on reaching 0; arithmetic in DATA_W+1 bits.
REQ-024 Mode 11: code alternates level, 0, level, ... starting with level after mode entry.
REQ-025 mode is sampled only at ticks; on a tick whose mode differs from the previous tick's mode, accumulator restarts at 0, direction = up, square phase = high, before computing the sample.
REQ-026 step == 0 SHALL yield a constant code (prev) in modes 01/10 without direction flip.
REQ-027 rate_div == 0 SHALL tick every enabled cycle.

Reset
REQ-028 reset low SHALL immediately clear DATA = 0, data_valid = 0, overrun = 0, divider = 0, accumulator = 0, direction = up, square phase = high, stored mode = 00.
REQ-029 Reset mid-handshake SHALL discard the pending sample; first tick after release behaves as a mode entry.

Structure
REQ-030 Shared package dac_pkg SHALL hold DATA_W, mode encodings (MODE_CONST/SAW/TRI/SQR) and FULL_SCALE = 2^DATA_W - 1.
REQ-031 Divider SHALL be a sub-module rate_ticker (clk, reset, en, rate_div -> tick).
REQ-032 Output handshake register and waveform arithmetic stay in dac_wave_gen.

Verification
REQ-033 Saw: mode 01, step 1024, rate_div 9, dac_ready 1 -> DATA 1024, 2048, 3072, 0, 1024 at 10-cycle spacing, overrun 0.
REQ-034 Triangle: mode 10, step 1500 -> DATA 1500, 3000, 4095, 2595, 1095, 0, 1500.
REQ-035 Backpressure: dac_ready 0 for 35 cycles, rate_div 9 -> DATA frozen, overrun 3, generator resumes from frozen value +step.
REQ-036 Square: mode 11, level 12'hCCC -> DATA CCC, 000, CCC; switch to mode 00 -> CCC constant.
REQ-037 Reset pulse low while data_valid = 1 -> DATA 0, data_valid 0, overrun 0 immediately, without a clock edge.
REQ-038 en 0 for 50 cycles -> no data_valid rise, divider restarts from 0 on en 1.
